// File: rtl/wdt_reset_ctrl.sv
// wdt_reset_ctrl: turns the watchdog wrapper's timeout level into a CPU
// interrupt with a grace window. If software does not acknowledge the
// interrupt before the window closes, the block issues a fixed-width system
// reset pulse. It also keeps a sticky "watchdog caused the last reset" flag
// and a saturating count of watchdog resets.
//
// Optional build macro: WTO_FILTER_EN
//   When defined, wto_i must be high for FILTER_CYCLES consecutive samples
//   before it can start the interrupt sequence, so short glitches are ignored.
//   When undefined, wto_i starts the sequence directly.
module wdt_reset_ctrl #(
  parameter int GRACE_CYCLES  = 1024,
  parameter int RST_CYCLES    = 16,
  parameter int CNT_W         = 8,
  parameter int FILTER_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wto_i,
  input  logic             irq_ack,
  input  logic             cause_clr,
  output logic             irq_o,
  output logic             sys_rst_o,
  output logic             wdt_cause_o,
  output logic [CNT_W-1:0] reset_cnt_o
);

  // One down-counter serves both the grace window and the reset pulse, so it
  // is sized for whichever of the two is longer.
  localparam int MAX_CYC = (GRACE_CYCLES > RST_CYCLES) ? GRACE_CYCLES : RST_CYCLES;
  localparam int TMR_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [TMR_W-1:0] GRACE_LOAD = TMR_W'(GRACE_CYCLES - 1);
  localparam logic [TMR_W-1:0] RST_LOAD   = TMR_W'(RST_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_IRQ,
    ST_RST,
    ST_HOLD
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic [TMR_W-1:0] r_timer;
  logic [TMR_W-1:0] w_timerNext;
  logic             w_irqNext;
  logic             w_sysRstNext;
  logic             w_causeNext;
  logic [CNT_W-1:0] w_cntNext;
  logic             w_wtoQ;

`ifdef WTO_FILTER_EN
  localparam int               FILT_W    = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_CYCLES - 1);

  logic [FILT_W-1:0] r_filtCnt;

  // Count consecutive high samples of wto_i, holding at FILTER_CYCLES-1; any low sample restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_filtCnt <= '0;
    end else if (!wto_i) begin
      r_filtCnt <= '0;
    end else if (r_filtCnt != FILT_LAST) begin
      r_filtCnt <= r_filtCnt + FILT_W'(1);
    end
  end

  // The current high sample qualifies only once FILTER_CYCLES-1 earlier highs were seen.
  assign w_wtoQ = wto_i && (r_filtCnt == FILT_LAST);
`else
  // Without the filter the raw level qualifies directly; FILTER_CYCLES has no role beyond its legal-range bound.
  assign w_wtoQ = wto_i & (FILTER_CYCLES >= 1);
`endif

  // Next-state, timer and next-output logic; every register holds unless a branch changes it.
  always_comb begin
    w_stateNext  = r_state;
    w_timerNext  = r_timer;
    w_irqNext    = irq_o;
    w_sysRstNext = sys_rst_o;
    w_causeNext  = wdt_cause_o;
    w_cntNext    = reset_cnt_o;

    // Software clear first, so a reset being issued on the same edge still sets the flag and counts from zero.
    if (cause_clr) begin
      w_causeNext = 1'b0;
      w_cntNext   = '0;
    end

    case (r_state)
      ST_IDLE: begin
        if (w_wtoQ) begin
          w_stateNext = ST_IRQ;
          w_timerNext = GRACE_LOAD;
          w_irqNext   = 1'b1;
        end
      end

      ST_IRQ: begin
        if (irq_ack) begin
          w_stateNext = ST_HOLD;
          w_irqNext   = 1'b0;
        end else if (r_timer == '0) begin
          w_stateNext  = ST_RST;
          w_timerNext  = RST_LOAD;
          w_irqNext    = 1'b0;
          w_sysRstNext = 1'b1;
          w_causeNext  = 1'b1;
          if (w_cntNext != '1) begin
            w_cntNext = w_cntNext + CNT_W'(1);
          end
        end else begin
          w_timerNext = r_timer - TMR_W'(1);
        end
      end

      ST_RST: begin
        if (r_timer == '0) begin
          w_stateNext  = ST_HOLD;
          w_sysRstNext = 1'b0;
        end else begin
          w_timerNext = r_timer - TMR_W'(1);
        end
      end

      ST_HOLD: begin
        if (!wto_i) begin
          w_stateNext = ST_IDLE;
        end
      end

      default: begin
        w_stateNext  = ST_IDLE;
        w_irqNext    = 1'b0;
        w_sysRstNext = 1'b0;
      end
    endcase
  end

  // State, timer and all outputs are registered; rst aborts any sequence in progress on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      irq_o       <= 1'b0;
      sys_rst_o   <= 1'b0;
      wdt_cause_o <= 1'b0;
      reset_cnt_o <= '0;
    end else begin
      r_state     <= w_stateNext;
      r_timer     <= w_timerNext;
      irq_o       <= w_irqNext;
      sys_rst_o   <= w_sysRstNext;
      wdt_cause_o <= w_causeNext;
      reset_cnt_o <= w_cntNext;
    end
  end

endmodule

// File: tb/tb_wdt_reset_ctrl.sv
// tb_wdt_reset_ctrl: directed self-checking bench for wdt_reset_ctrl with a
// short grace window (8), short reset pulse (4) and a 2-bit reset counter.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_wdt_reset_ctrl;

  localparam int GRACE = 8;
  localparam int RSTC  = 4;
  localparam int CNTW  = 2;
  localparam int FILT  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            wto;
  logic            ack;
  logic            clr;
  logic            irq;
  logic            sysRst;
  logic            cause;
  logic [CNTW-1:0] cnt;

  int total = 0;
  int bad   = 0;

  wdt_reset_ctrl #(
    .GRACE_CYCLES (GRACE),
    .RST_CYCLES   (RSTC),
    .CNT_W        (CNTW),
    .FILTER_CYCLES(FILT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wto_i      (wto),
    .irq_ack    (ack),
    .cause_clr  (clr),
    .irq_o      (irq),
    .sys_rst_o  (sysRst),
    .wdt_cause_o(cause),
    .reset_cnt_o(cnt)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic checkState(input string tag, input int eIrq, input int eRst, input int eCause, input int eCnt);
    checkOutput({tag, ".irq"}, 32'(irq), 32'(eIrq));
    checkOutput({tag, ".sysRst"}, 32'(sysRst), 32'(eRst));
    checkOutput({tag, ".cause"}, 32'(cause), 32'(eCause));
    checkOutput({tag, ".cnt"}, 32'(cnt), 32'(eCnt));
  endtask

  task automatic applyStimulus(input logic w, input logic a, input logic c, input logic r);
    wto = w;
    ack = a;
    clr = c;
    rst = r;
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Rearm from HOLD, trigger, let the grace window expire and finish the pulse.
  task automatic runTimeout(input int expCnt);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("satIrq", 32'(irq), 32'd1);
    step(GRACE);
    checkState("satRst", 0, 1, 1, expCnt);
    step(RSTC);
    checkOutput("satPulseEnd", 32'(sysRst), 32'd0);
  endtask

  initial begin
    // Reset state
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    step(2);
    checkState("reset", 0, 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    checkState("idle", 0, 0, 0, 0);

    // Timeout with no ack: irq for GRACE cycles then sys_rst for RSTC cycles
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    for (int i = 0; i < GRACE; i++) begin
      checkOutput("graceIrq", 32'(irq), 32'd1);
      checkOutput("graceNoRst", 32'(sysRst), 32'd0);
      step();
    end
    checkState("rstEntry", 0, 1, 1, 1);
    for (int i = 0; i < RSTC; i++) begin
      checkOutput("rstPulse", 32'(sysRst), 32'd1);
      step();
    end
    checkState("rstDone", 0, 0, 1, 1);

    // wto held high: HOLD must not retrigger
    step(5);
    checkState("holdNoRetrig", 0, 0, 1, 1);

    // wto low for one edge rearms; next high sample enters IRQ
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("rearm", 32'(irq), 32'd1);

    // Ack mid-window suppresses the reset
    step(3);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkState("ackMid", 0, 0, 1, 1);
    step(12);
    checkState("ackNoRst", 0, 0, 1, 1);

    // Ack on the final grace cycle wins over the timer expiring
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    step(GRACE - 1);
    checkOutput("lastGraceIrq", 32'(irq), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkState("ackLast", 0, 0, 1, 1);
    step(6);
    checkOutput("ackLastNoRst", 32'(sysRst), 32'd0);

    // Counter saturates at all-ones
    runTimeout(2);
    runTimeout(3);
    runTimeout(3);

    // cause_clr clears flag and count
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkState("clr", 0, 0, 0, 0);

    // cause_clr on the reset-entry edge: set/increment wins
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    step(GRACE - 1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
    step();
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    checkState("clrRace", 0, 1, 1, 1);

    // rst during the third pulse cycle aborts everything
    step(2);
    checkOutput("pulseCycle3", 32'(sysRst), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
    step();
    checkState("midRst", 0, 0, 0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("postRstIrq", 32'(irq), 32'd1);

    // Leave IRQ via ack, then stray ack/clear in IDLE do nothing
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    step();
    checkState("ackIdle", 0, 0, 0, 0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step(3);
    checkState("clrZeroIdle", 0, 0, 0, 0);

`ifdef WTO_FILTER_EN
    // A pulse shorter than the filter length never triggers
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < FILT - 1; i++) begin
      step();
      checkOutput("filtShort", 32'(irq), 32'd0);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step(4);
    checkOutput("filtShortAfter", 32'(irq), 32'd0);

    // Sustained high triggers on the FILT-th high sample
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < FILT - 1; i++) begin
      step();
      checkOutput("filtWait", 32'(irq), 32'd0);
    end
    step();
    checkOutput("filtEntry", 32'(irq), 32'd1);
`else
    // Without the filter a single high sample triggers and IRQ persists after wto drops
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    checkOutput("rawEntry", 32'(irq), 32'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    step(3);
    checkOutput("rawHoldIrq", 32'(irq), 32'd1);
`endif

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    step();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    checkState("finalAck", 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
